multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 41 ++++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// and the ALUOp / ALUSrcB / PCSource select values used by datapath and ALU control.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_ERROR  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_IMM    = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH = 3'b011;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath, with a wait counter that
// stretches instruction fetch and data reads over MEM_WAIT extra memory cycles.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [2:0] ALUSrcB,
  output logic [3:0] state_o,
  output logic       err
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wait_done;

  assign wait_done = (cnt_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:  if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: state_d = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (wait_done) state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ERROR:  state_d = S_ERROR;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    // Counter restarts on entry to a memory-wait state and saturates rather than wrapping.
    if ((state_d == S_FETCH || state_d == S_MEMRD) && state_d != state_q)
      cnt_d = 3'd0;
    else if ((state_q == S_FETCH || state_q == S_MEMRD) && cnt_q != 3'd7)
      cnt_d = cnt_q + 3'd1;
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_B;
    err         = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        // Instruction latch and PC increment happen once, on the last wait cycle.
        if (wait_done) begin
          IRWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_TARGET;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_ERROR:  err = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule
